// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message-schedule datapath: FSM encoding,
// sliding-window geometry/taps and default sigma constants for 32/64-bit modes.
package sha2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StGen,
    StDrain
  } sched_state_e;

  localparam int unsigned WINDOW_DEPTH = 16;

  // Window taps for W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  localparam int unsigned TAP_S1  = 14;
  localparam int unsigned TAP_W7  = 9;
  localparam int unsigned TAP_S0  = 1;
  localparam int unsigned TAP_W16 = 0;

  // SHA-224/256 sigma constants
  localparam int unsigned SIG0_ROT_A_256 = 7;
  localparam int unsigned SIG0_ROT_B_256 = 18;
  localparam int unsigned SIG0_SHR_256   = 3;
  localparam int unsigned SIG1_ROT_A_256 = 17;
  localparam int unsigned SIG1_ROT_B_256 = 19;
  localparam int unsigned SIG1_SHR_256   = 10;

  // SHA-384/512 sigma constants
  localparam int unsigned SIG0_ROT_A_512 = 1;
  localparam int unsigned SIG0_ROT_B_512 = 8;
  localparam int unsigned SIG0_SHR_512   = 7;
  localparam int unsigned SIG1_ROT_A_512 = 19;
  localparam int unsigned SIG1_ROT_B_512 = 61;
  localparam int unsigned SIG1_SHR_512   = 6;

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-2 small sigma: ROTR(x,a) ^ ROTR(x,b) ^ SHR(x,s).
// A rotate amount of 0 passes the word through unchanged.
module sha2_sigma #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned SH_W   = $clog2(WORD_W)
) (
  input  logic [WORD_W-1:0] x_i,
  input  logic [SH_W-1:0]   rot_a_i,
  input  logic [SH_W-1:0]   rot_b_i,
  input  logic [SH_W-1:0]   shr_i,
  output logic [WORD_W-1:0] y_o
);

  localparam logic [SH_W:0] WordW = (SH_W + 1)'(WORD_W);

  // Left shift by WORD_W - n; n == 0 shifts everything out, leaving x >> 0
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input logic [SH_W-1:0]   n);
    logic [SH_W:0] lsh;
    lsh = WordW - {1'b0, n};
    return (x >> n) | (x << lsh);
  endfunction

  // XOR of the two rotations and the logical shift
  always_comb begin
    y_o = rotr(x_i, rot_a_i) ^ rotr(x_i, rot_b_i) ^ (x_i >> shr_i);
  end

endmodule

// File: rtl/msg_schedule_unit.sv
// Streaming SHA-2 message-schedule generator. Loads 16 message words (echoing
// each as W[0..15]) and then expands W[16..ROUNDS-1] from a 16-word sliding
// window through a single-entry output register with valid/ready handshake.
// Optional build macro: MSG_SCHEDULE_STALL_CNT_EN adds the stall_cnt_o counter.
module msg_schedule_unit
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = $clog2(ROUNDS),
  parameter int unsigned SH_W   = $clog2(WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  input  logic [SH_W-1:0]   sigma0_rot_a_i,
  input  logic [SH_W-1:0]   sigma0_rot_b_i,
  input  logic [SH_W-1:0]   sigma0_shr_i,
  input  logic [SH_W-1:0]   sigma1_rot_a_i,
  input  logic [SH_W-1:0]   sigma1_rot_b_i,
  input  logic [SH_W-1:0]   sigma1_shr_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  out_idx_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
`ifdef MSG_SCHEDULE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] LastLoad  = CNT_W'(WINDOW_DEPTH - 1);
  localparam logic [CNT_W-1:0] LastRound = CNT_W'(ROUNDS - 1);

  sched_state_e      state_q;
  logic [CNT_W-1:0]  t_q;
  logic [WORD_W-1:0] out_data_q;
  logic [CNT_W-1:0]  out_idx_q;
  logic              out_valid_q;
  logic              done_q;
  logic [WORD_W-1:0] win_q [WINDOW_DEPTH];

  logic              free;
  logic              load_fire;
  logic              gen_fire;
  logic              push;
  logic              run_accept;
  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;
  logic [WORD_W-1:0] gen_word;
  logic [WORD_W-1:0] push_word;

  sha2_sigma #(
    .WORD_W (WORD_W),
    .SH_W   (SH_W)
  ) u_sigma0 (
    .x_i     (win_q[TAP_S0]),
    .rot_a_i (sigma0_rot_a_i),
    .rot_b_i (sigma0_rot_b_i),
    .shr_i   (sigma0_shr_i),
    .y_o     (sig0)
  );

  sha2_sigma #(
    .WORD_W (WORD_W),
    .SH_W   (SH_W)
  ) u_sigma1 (
    .x_i     (win_q[TAP_S1]),
    .rot_a_i (sigma1_rot_a_i),
    .rot_b_i (sigma1_rot_b_i),
    .shr_i   (sigma1_shr_i),
    .y_o     (sig1)
  );

  // Handshake decode and next schedule word (sum wraps modulo 2^WORD_W)
  always_comb begin
    free       = !out_valid_q || out_ready_i;
    load_fire  = (state_q == StLoad) && in_valid_i && free;
    gen_fire   = (state_q == StGen) && free;
    push       = load_fire || gen_fire;
    // done_q marks the first IDLE cycle; a run pulse there is ignored
    run_accept = (state_q == StIdle) && run_i && !done_q;
    gen_word   = sig1 + win_q[TAP_W7] + sig0 + win_q[TAP_W16];
    push_word  = load_fire ? in_data_i : gen_word;
  end

  // Control FSM with registered output beat, round counter and done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      t_q         <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        out_data_q  <= push_word;
        out_idx_q   <= t_q;
        out_valid_q <= 1'b1;
        t_q         <= t_q + 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (run_accept) begin
            state_q <= StLoad;
            t_q     <= '0;
          end
        end
        StLoad: begin
          if (load_fire && (t_q == LastLoad)) state_q <= StGen;
        end
        StGen: begin
          if (gen_fire && (t_q == LastRound)) state_q <= StDrain;
        end
        StDrain: begin
          if (out_valid_q && out_ready_i) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sliding window: oldest word at index 0, every push shifts toward it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WINDOW_DEPTH; i++) win_q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < WINDOW_DEPTH - 1; i++) win_q[i] <= win_q[i+1];
      win_q[WINDOW_DEPTH-1] <= push_word;
    end
  end

`ifdef MSG_SCHEDULE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of busy cycles where the consumer holds off a valid beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (run_accept) begin
      stall_cnt_q <= '0;
    end else if ((state_q != StIdle) && out_valid_q && !out_ready_i &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  // Output port mapping
  always_comb begin
    in_ready_o  = (state_q == StLoad) && free;
    out_data_o  = out_data_q;
    out_idx_o   = out_idx_q;
    out_valid_o = out_valid_q;
    out_last_o  = out_valid_q && (out_idx_q == LastRound);
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
  end

endmodule

// File: tb/tb_msg_schedule_unit.sv
// Self-checking bench for msg_schedule_unit: SHA-256 and SHA-512 "abc" schedules,
// backpressure, gapped loading, asynchronous reset and the optional stall counter.
module tb_msg_schedule_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        run32, in_valid32, out_ready32;
  logic [31:0] in_data32;
  logic        in_ready32, out_valid32, out_last32, busy32, done32;
  logic [31:0] out_data32;
  logic [5:0]  out_idx32;

  logic        run64, in_valid64, out_ready64;
  logic [63:0] in_data64;
  logic        in_ready64, out_valid64, out_last64, busy64, done64;
  logic [63:0] out_data64;
  logic [6:0]  out_idx64;

`ifdef MSG_SCHEDULE_STALL_CNT_EN
  logic [31:0] stall32, stall64;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] blk32 [16];
  logic [63:0] blk64 [16];
  logic [31:0] exp32 [64];
  logic [63:0] exp64 [80];

  msg_schedule_unit #(
    .WORD_W (32),
    .ROUNDS (64)
  ) u_dut32 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .run_i          (run32),
    .sigma0_rot_a_i (5'd7),
    .sigma0_rot_b_i (5'd18),
    .sigma0_shr_i   (5'd3),
    .sigma1_rot_a_i (5'd17),
    .sigma1_rot_b_i (5'd19),
    .sigma1_shr_i   (5'd10),
    .in_data_i      (in_data32),
    .in_valid_i     (in_valid32),
    .in_ready_o     (in_ready32),
    .out_data_o     (out_data32),
    .out_idx_o      (out_idx32),
    .out_valid_o    (out_valid32),
    .out_ready_i    (out_ready32),
    .out_last_o     (out_last32),
    .busy_o         (busy32),
    .done_o         (done32)
`ifdef MSG_SCHEDULE_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall32)
`endif
  );

  msg_schedule_unit #(
    .WORD_W (64),
    .ROUNDS (80)
  ) u_dut64 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .run_i          (run64),
    .sigma0_rot_a_i (6'd1),
    .sigma0_rot_b_i (6'd8),
    .sigma0_shr_i   (6'd7),
    .sigma1_rot_a_i (6'd19),
    .sigma1_rot_b_i (6'd61),
    .sigma1_shr_i   (6'd6),
    .in_data_i      (in_data64),
    .in_valid_i     (in_valid64),
    .in_ready_o     (in_ready64),
    .out_data_o     (out_data64),
    .out_idx_o      (out_idx64),
    .out_valid_o    (out_valid64),
    .out_ready_i    (out_ready64),
    .out_last_o     (out_last64),
    .busy_o         (busy64),
    .done_o         (done64)
`ifdef MSG_SCHEDULE_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall64)
`endif
  );

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build_models();
    logic [31:0] a0, a1;
    logic [63:0] b0, b1;
    for (int i = 0; i < 16; i++) begin
      blk32[i] = '0;
      blk64[i] = '0;
    end
    blk32[0]  = 32'h6162_6380;
    blk32[15] = 32'h0000_0018;
    blk64[0]  = 64'h6162_6380_0000_0000;
    blk64[15] = 64'h0000_0000_0000_0018;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp32[t] = blk32[t];
      else begin
        a0 = rotr32(exp32[t-15], 7) ^ rotr32(exp32[t-15], 18) ^ (exp32[t-15] >> 3);
        a1 = rotr32(exp32[t-2], 17) ^ rotr32(exp32[t-2], 19) ^ (exp32[t-2] >> 10);
        exp32[t] = a1 + exp32[t-7] + a0 + exp32[t-16];
      end
    end
    for (int t = 0; t < 80; t++) begin
      if (t < 16) exp64[t] = blk64[t];
      else begin
        b0 = rotr64(exp64[t-15], 1) ^ rotr64(exp64[t-15], 8) ^ (exp64[t-15] >> 7);
        b1 = rotr64(exp64[t-2], 19) ^ rotr64(exp64[t-2], 61) ^ (exp64[t-2] >> 6);
        exp64[t] = b1 + exp64[t-7] + b0 + exp64[t-16];
      end
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low 7 cycles from W20
  // gap: idle cycles inserted after each accepted input word
  // poke_done: raise run in the done cycle (must be ignored)
  task automatic run256(input int mode, input int gap, input bit poke_done);
    int n_in = 0, n_out = 0, cyc = 0, dones = 0, gapc = 0, stall_left = 0;
    bit stall_started = 0, held = 0;
    logic [31:0] held_d = '0;
    logic [5:0]  held_i = '0;
    logic        exp_rdy;
    @(posedge clk); #1 run32 = 1'b1;
    @(posedge clk); #1 run32 = 1'b0;
    while (dones == 0 && cyc < 1000) begin
      in_valid32 = (n_in < 16) && (gapc == 0);
      in_data32  = '0;
      if (n_in < 16) in_data32 = blk32[n_in];
      if (mode == 2 && !stall_started && n_out == 20) begin
        stall_started = 1;
        stall_left    = 7;
      end
      if (mode == 1) out_ready32 = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready32 = (stall_left == 0);
      else out_ready32 = 1'b1;
      @(negedge clk);
`ifdef MSG_SCHEDULE_STALL_CNT_EN
      if (cyc == 0) begin
        checks++;
        if (stall32 !== 32'd0) begin
          errors++;
          $display("FAIL stall_clear got %0d want 0", stall32);
        end
      end
`endif
      exp_rdy = (n_in < 16) ? (!out_valid32 || out_ready32) : 1'b0;
      checks++;
      if (in_ready32 !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready n_in=%0d got %b want %b", n_in, in_ready32, exp_rdy);
      end
      if (held) begin
        checks++;
        if (out_data32 !== held_d || out_idx32 !== held_i) begin
          errors++;
          $display("FAIL stall_hold got %0d:%h want %0d:%h", out_idx32, out_data32,
                   held_i, held_d);
        end
      end
      held = 0;
      if (out_valid32) begin
        if (out_ready32) begin
          checks++;
          if (n_out >= 64) begin
            errors++;
            $display("FAIL extra_word got idx %0d want none", out_idx32);
          end else if (out_idx32 !== 6'(n_out) || out_data32 !== exp32[n_out]
                       || out_last32 !== (n_out == 63)) begin
            errors++;
            $display("FAIL word got %0d:%h last=%b want %0d:%h last=%b", out_idx32,
                     out_data32, out_last32, n_out, exp32[n_out], (n_out == 63));
          end
          if (n_out == 16 || n_out == 17 || n_out == 18) begin
            checks++;
            if ((n_out == 16 && out_data32 !== 32'h6162_6380) ||
                (n_out == 17 && out_data32 !== 32'h000F_0000) ||
                (n_out == 18 && out_data32 !== 32'h7DA8_6405)) begin
              errors++;
              $display("FAIL w%0d_const got %h", n_out, out_data32);
            end
          end
          n_out++;
        end else begin
          held   = 1;
          held_d = out_data32;
          held_i = out_idx32;
        end
      end
      if (in_valid32 && in_ready32) begin
        n_in++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
      if (mode == 2 && !out_ready32 && stall_left > 0) stall_left--;
      if (done32) begin
        dones++;
`ifdef MSG_SCHEDULE_STALL_CNT_EN
        if (mode == 2) begin
          checks++;
          if (stall32 !== 32'd7) begin
            errors++;
            $display("FAIL stall_cnt got %0d want 7", stall32);
          end
        end
`endif
        if (poke_done) run32 = 1'b1;
      end
      cyc++;
      @(posedge clk); #1;
      run32 = 1'b0;
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    checks++;
    if (dones != 1 || n_out != 64) begin
      errors++;
      $display("FAIL completion got dones=%0d words=%0d want 1 64", dones, n_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
        errors++;
        $display("FAIL post_done got done=%b busy=%b want 0 0", done32, busy32);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b0 || busy32 !== 1'b0 ||
        done32 !== 1'b0 || out_data32 !== '0 || out_idx32 !== '0) begin
      errors++;
      $display("FAIL reset32 got v=%b r=%b b=%b d=%b data=%h idx=%0d want zeros",
               out_valid32, in_ready32, busy32, done32, out_data32, out_idx32);
    end
    checks++;
    if (out_valid64 !== 1'b0 || busy64 !== 1'b0 || out_data64 !== '0) begin
      errors++;
      $display("FAIL reset64 got v=%b b=%b data=%h want zeros",
               out_valid64, busy64, out_data64);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abc256();
    run256(0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run256(1, 0, 1'b0);
  endtask

  task automatic test_gapped_load();
    run256(0, 2, 1'b0);
  endtask

  task automatic test_abc512();
    int n_in = 0, n_out = 0, cyc = 0, dones = 0;
    @(posedge clk); #1 run64 = 1'b1;
    @(posedge clk); #1 run64 = 1'b0;
    out_ready64 = 1'b1;
    while (dones == 0 && cyc < 1000) begin
      in_valid64 = (n_in < 16);
      in_data64  = '0;
      if (n_in < 16) in_data64 = blk64[n_in];
      @(negedge clk);
      if (out_valid64) begin
        checks++;
        if (n_out >= 80) begin
          errors++;
          $display("FAIL extra_word64 got idx %0d want none", out_idx64);
        end else if (out_idx64 !== 7'(n_out) || out_data64 !== exp64[n_out] ||
                     out_last64 !== (n_out == 79)) begin
          errors++;
          $display("FAIL word64 got %0d:%h last=%b want %0d:%h", out_idx64, out_data64,
                   out_last64, n_out, exp64[n_out]);
        end
        if (n_out == 16) begin
          checks++;
          if (out_data64 !== 64'h6162_6380_0000_0000) begin
            errors++;
            $display("FAIL w16_512 got %h want 6162638000000000", out_data64);
          end
        end
        n_out++;
      end
      if (in_valid64 && in_ready64) n_in++;
      if (done64) dones++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
    checks++;
    if (dones != 1 || n_out != 80) begin
      errors++;
      $display("FAIL completion64 got dones=%0d words=%0d want 1 80", dones, n_out);
    end
  endtask

  task automatic test_async_reset();
    int n_in = 0, cyc = 0;
    bit hit = 0;
    @(posedge clk); #1 run32 = 1'b1;
    @(posedge clk); #1 run32 = 1'b0;
    out_ready32 = 1'b1;
    while (!hit && cyc < 200) begin
      in_valid32 = (n_in < 16);
      in_data32  = '0;
      if (n_in < 16) in_data32 = blk32[n_in];
      @(negedge clk);
      if (in_valid32 && in_ready32) n_in++;
      if (out_valid32 && out_idx32 == 6'd30) hit = 1;
      cyc++;
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_idx30 got no beat 30 want beat 30");
    end
    #2 rst_n = 1'b0;
    in_valid32 = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_data32 !== '0 || out_idx32 !== '0 ||
        busy32 !== 1'b0 || in_ready32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b data=%h idx=%0d b=%b r=%b d=%b want zeros",
               out_valid32, out_data32, out_idx32, busy32, in_ready32, done32);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
        errors++;
        $display("FAIL spurious_done got done=%b busy=%b want 0 0", done32, busy32);
      end
    end
    run256(0, 0, 1'b0);
  endtask

`ifdef MSG_SCHEDULE_STALL_CNT_EN
  task automatic test_stall_cnt();
    run256(2, 0, 1'b0);
    run256(0, 0, 1'b0);
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    run32       = 1'b0;
    in_valid32  = 1'b0;
    in_data32   = '0;
    out_ready32 = 1'b1;
    run64       = 1'b0;
    in_valid64  = 1'b0;
    in_data64   = '0;
    out_ready64 = 1'b1;
    build_models();
    test_reset();
    test_abc256();
    test_backpressure();
    test_abc512();
    test_gapped_load();
    test_async_reset();
`ifdef MSG_SCHEDULE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
